dift_trap_recorder: RTL and testbench

- Receiving end of the DIFT tag-check trap interface: consumes the single-cycle trap pulse and trap type produced by the tag check unit.
- Records each trap event, with its PC and offending tag, into a small FIFO.
- Raises a req/ack exception request towards the controller, one request per recorded event.
- Exposes the FIFO head, per-type event counters and a sticky overflow flag to the CSR file. The trap handler pops entries through the CSR interface.

---
 rtl/dift_trap_recorder.sv | 160 ++++++++++++++++
 tb/tb_dift_trap_recorder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dift_trap_recorder.sv
// DIFT trap recorder: queues tag-check trap events, raises one exception
// request per queued event and exposes head, counters and overflow to CSRs.
module dift_trap_recorder #(
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       trap_i,
    input  logic [2:0]                 trap_type_i,
    input  logic [31:0]                trap_pc_i,
    input  logic [3:0]                 trap_tag_i,
    output logic                       exc_req_o,
    output logic [2:0]                 exc_type_o,
    input  logic                       exc_ack_i,
    input  logic                       csr_pop_i,
    output logic                       csr_valid_o,
    output logic [2:0]                 csr_head_type_o,
    output logic [31:0]                csr_head_pc_o,
    output logic [3:0]                 csr_head_tag_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o,
    input  logic                       overflow_clr_i,
    input  logic [2:0]                 cnt_sel_i,
    output logic [CNT_WIDTH-1:0]       cnt_o,
    input  logic                       cnt_clr_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t                state_q, state_d;
    logic [2:0]            type_q [DEPTH];
    logic [2:0]            type_d [DEPTH];
    logic [31:0]           pc_q   [DEPTH];
    logic [31:0]           pc_d   [DEPTH];
    logic [3:0]            tag_q  [DEPTH];
    logic [3:0]            tag_d  [DEPTH];
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [CNT_WIDTH-1:0]  cnt_q [5];
    logic [CNT_WIDTH-1:0]  cnt_d [5];

    logic valid_ev, empty, full, pop_ok, push_ok, drop;

    assign valid_ev = trap_i && (trap_type_i >= 3'd1) && (trap_type_i <= 3'd5);
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign pop_ok   = csr_pop_i && !empty;
    // A pop at full frees the slot this cycle's push lands in.
    assign push_ok  = valid_ev && (!full || pop_ok);
    assign drop     = valid_ev && full && !pop_ok;

    always_comb begin
        type_d     = type_q;
        pc_d       = pc_q;
        tag_d      = tag_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push_ok) begin
            type_d[wr_ptr_q] = trap_type_i;
            pc_d[wr_ptr_q]   = trap_pc_i;
            tag_d[wr_ptr_q]  = trap_tag_i;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop_ok)
            rd_ptr_d = rd_ptr_q + PW'(1);
        if (push_ok && !pop_ok)
            count_d = count_q + CW'(1);
        else if (pop_ok && !push_ok)
            count_d = count_q - CW'(1);
        if (drop)
            overflow_d = 1'b1;
        else if (overflow_clr_i)
            overflow_d = 1'b0;
    end

    // Per-type saturating counters; a clear beats a coincident increment.
    always_comb begin
        cnt_d = cnt_q;
        for (int t = 0; t < 5; t++) begin
            if (cnt_clr_i && cnt_sel_i == 3'(t + 1))
                cnt_d[t] = '0;
            else if (valid_ev && trap_type_i == 3'(t + 1) && cnt_q[t] != '1)
                cnt_d[t] = cnt_q[t] + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                type_q[i] <= '0;
                pc_q[i]   <= '0;
                tag_q[i]  <= '0;
            end
            for (int t = 0; t < 5; t++)
                cnt_q[t] <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            type_q     <= type_d;
            pc_q       <= pc_d;
            tag_q      <= tag_d;
            cnt_q      <= cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!empty) state_d = REQ;
            REQ: begin
                if (exc_ack_i)   state_d = SERVICE;
                else if (pop_ok) state_d = IDLE;
            end
            SERVICE: if (csr_pop_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        exc_req_o       = (state_q == REQ);
        csr_valid_o     = !empty;
        csr_head_type_o = empty ? 3'd0  : type_q[rd_ptr_q];
        csr_head_pc_o   = empty ? 32'd0 : pc_q[rd_ptr_q];
        csr_head_tag_o  = empty ? 4'd0  : tag_q[rd_ptr_q];
        exc_type_o      = exc_req_o ? csr_head_type_o : 3'd0;
        count_o         = count_q;
        overflow_o      = overflow_q;
        cnt_o           = '0;
        unique case (cnt_sel_i)
            3'd1:    cnt_o = cnt_q[0];
            3'd2:    cnt_o = cnt_q[1];
            3'd3:    cnt_o = cnt_q[2];
            3'd4:    cnt_o = cnt_q[3];
            3'd5:    cnt_o = cnt_q[4];
            default: cnt_o = '0;
        endcase
    end

endmodule

// File: tb/tb_dift_trap_recorder.sv
// Bench for dift_trap_recorder: directed scenarios plus random traffic,
// all outputs compared each cycle against a queue-based reference model.
module tb_dift_trap_recorder;

    localparam int DEPTH = 4;
    localparam int CNT_WIDTH = 16;
    localparam int CMAX = 65535;

    logic        clk, rst_n;
    logic        trap_i;
    logic [2:0]  trap_type_i;
    logic [31:0] trap_pc_i;
    logic [3:0]  trap_tag_i;
    logic        exc_req_o;
    logic [2:0]  exc_type_o;
    logic        exc_ack_i;
    logic        csr_pop_i;
    logic        csr_valid_o;
    logic [2:0]  csr_head_type_o;
    logic [31:0] csr_head_pc_o;
    logic [3:0]  csr_head_tag_o;
    logic [2:0]  count_o;
    logic        overflow_o;
    logic        overflow_clr_i;
    logic [2:0]  cnt_sel_i;
    logic [15:0] cnt_o;
    logic        cnt_clr_i;

    dift_trap_recorder #(.DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .trap_i(trap_i), .trap_type_i(trap_type_i),
        .trap_pc_i(trap_pc_i), .trap_tag_i(trap_tag_i),
        .exc_req_o(exc_req_o), .exc_type_o(exc_type_o),
        .exc_ack_i(exc_ack_i), .csr_pop_i(csr_pop_i),
        .csr_valid_o(csr_valid_o), .csr_head_type_o(csr_head_type_o),
        .csr_head_pc_o(csr_head_pc_o), .csr_head_tag_o(csr_head_tag_o),
        .count_o(count_o), .overflow_o(overflow_o),
        .overflow_clr_i(overflow_clr_i), .cnt_sel_i(cnt_sel_i),
        .cnt_o(cnt_o), .cnt_clr_i(cnt_clr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  t;
        logic [31:0] pc;
        logic [3:0]  tag;
    } ent_t;

    ent_t mq[$];
    int   mcnt[8];
    int   mphase;
    bit   movf;
    int   nvec;
    int   nerr;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 8; i++) mcnt[i] = 0;
        mphase = 0;
        movf = 1'b0;
    endtask

    // Phase 0: no request, 1: request outstanding, 2: handler servicing.
    task automatic model_step();
        int  sz;
        bit  valid, popok, drop;
        ent_t e;
        sz    = mq.size();
        valid = trap_i && trap_type_i >= 1 && trap_type_i <= 5;
        popok = csr_pop_i && sz > 0;
        drop  = valid && sz == DEPTH && !popok;
        case (mphase)
            0: if (sz != 0) mphase = 1;
            1: if (exc_ack_i) mphase = 2; else if (popok) mphase = 0;
            default: if (csr_pop_i) mphase = 0;
        endcase
        if (popok) void'(mq.pop_front());
        if (valid && !drop) begin
            e.t = trap_type_i; e.pc = trap_pc_i; e.tag = trap_tag_i;
            mq.push_back(e);
        end
        movf = drop ? 1'b1 : (overflow_clr_i ? 1'b0 : movf);
        for (int t = 1; t <= 5; t++) begin
            if (cnt_clr_i && cnt_sel_i == t) mcnt[t] = 0;
            else if (valid && trap_type_i == t && mcnt[t] < CMAX) mcnt[t]++;
        end
    endtask

    task automatic check_all();
        bit   ne;
        ent_t h;
        ne = mq.size() > 0;
        h.t = 0; h.pc = 0; h.tag = 0;
        if (ne) h = mq[0];
        chk("valid", 32'(csr_valid_o), 32'(ne));
        chk("head_type", 32'(csr_head_type_o), 32'(h.t));
        chk("head_pc", csr_head_pc_o, h.pc);
        chk("head_tag", 32'(csr_head_tag_o), 32'(h.tag));
        chk("count", 32'(count_o), 32'(mq.size()));
        chk("overflow", 32'(overflow_o), 32'(movf));
        chk("exc_req", 32'(exc_req_o), 32'(mphase == 1));
        chk("exc_type", 32'(exc_type_o), (mphase == 1) ? 32'(h.t) : 32'd0);
        chk("cnt", 32'(cnt_o), 32'(mcnt[cnt_sel_i]));
    endtask

    task automatic clr_in();
        trap_i = 0; trap_type_i = 0; trap_pc_i = 0; trap_tag_i = 0;
        exc_ack_i = 0; csr_pop_i = 0; overflow_clr_i = 0; cnt_clr_i = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        model_step();
        check_all();
        clr_in();
    endtask

    task automatic ev(input logic [2:0] t, input logic [31:0] pc,
                      input logic [3:0] tag);
        trap_i = 1; trap_type_i = t; trap_pc_i = pc; trap_tag_i = tag;
    endtask

    initial begin
        nvec = 0; nerr = 0;
        rst_n = 0; cnt_sel_i = 0;
        clr_in();
        model_reset();
        #12;
        check_all();
        chk("rst_req", 32'(exc_req_o), 0);
        chk("rst_count", 32'(count_o), 0);
        @(posedge clk); #1;
        rst_n = 1;

        // Single event and req/ack/pop handshake
        cnt_sel_i = 3;
        ev(3, 32'h1234, 4'h4); cyc();
        chk("t1_valid", 32'(csr_valid_o), 1);
        chk("t1_pc", csr_head_pc_o, 32'h1234);
        chk("t1_req_n1", 32'(exc_req_o), 0);
        cyc();
        chk("t1_req", 32'(exc_req_o), 1);
        chk("t1_type", 32'(exc_type_o), 3);
        cyc();
        exc_ack_i = 1; cyc();
        chk("t1_ack", 32'(exc_req_o), 0);
        csr_pop_i = 1; cyc();
        chk("t1_pop", 32'(csr_valid_o), 0);
        chk("t1_cnt", 32'(cnt_o), 1);
        cyc();

        // Fill and overflow
        cnt_sel_i = 1;
        for (int i = 0; i < 5; i++) begin
            ev(1, 32'h100 + i, 4'(i)); cyc();
        end
        chk("t2_count", 32'(count_o), 4);
        chk("t2_ovf", 32'(overflow_o), 1);
        chk("t2_cnt", 32'(cnt_o), 5);
        chk("t2_head", csr_head_pc_o, 32'h100);
        overflow_clr_i = 1; cyc();
        chk("t2_ovfclr", 32'(overflow_o), 0);

        // Push and pop at full, then drain across the wrap
        ev(1, 32'h200, 4'hA); csr_pop_i = 1; cyc();
        chk("t3_count", 32'(count_o), 4);
        chk("t3_ovf", 32'(overflow_o), 0);
        chk("t3_head", csr_head_pc_o, 32'h101);
        for (int i = 0; i < 3; i++) begin
            csr_pop_i = 1; cyc();
        end
        chk("t3_last", csr_head_pc_o, 32'h200);
        chk("t3_cnt1", 32'(count_o), 1);
        csr_pop_i = 1; cyc();
        chk("t3_empty", 32'(count_o), 0);
        cyc(); cyc();

        // Ignored trap types
        ev(0, 32'h300, 4'h1); cyc();
        ev(6, 32'h304, 4'h2); cyc();
        ev(7, 32'h308, 4'h3); cyc();
        chk("t4_count", 32'(count_o), 0);
        chk("t4_cnt1", 32'(cnt_o), 6);
        cnt_sel_i = 6; cyc();
        chk("t4_sel6", 32'(cnt_o), 0);
        cnt_sel_i = 3; cyc();
        chk("t4_cnt3", 32'(cnt_o), 1);

        // Ack without request, then back-to-back FSM sequencing
        exc_ack_i = 1; cyc();
        chk("t5_stray_ack", 32'(exc_req_o), 0);
        cyc();
        chk("t5_idle", 32'(exc_req_o), 0);
        ev(2, 32'h400, 4'h5); cyc();
        ev(4, 32'h404, 4'h6); cyc();
        chk("t5_req1", 32'(exc_req_o), 1);
        chk("t5_type1", 32'(exc_type_o), 2);
        exc_ack_i = 1; cyc();
        csr_pop_i = 1; cyc();
        chk("t5_gap", 32'(exc_req_o), 0);
        cyc();
        chk("t5_req2", 32'(exc_req_o), 1);
        chk("t5_type2", 32'(exc_type_o), 4);
        exc_ack_i = 1; cyc();
        csr_pop_i = 1; cyc();
        cyc();

        // Reset while a request is outstanding
        for (int i = 0; i < 3; i++) begin
            ev(5, 32'h500 + 4 * i, 4'hF); cyc();
        end
        chk("t6_req", 32'(exc_req_o), 1);
        rst_n = 0;
        #1;
        model_reset();
        chk("t6_rst_req", 32'(exc_req_o), 0);
        chk("t6_rst_valid", 32'(csr_valid_o), 0);
        chk("t6_rst_pc", csr_head_pc_o, 0);
        chk("t6_rst_count", 32'(count_o), 0);
        chk("t6_rst_type", 32'(exc_type_o), 0);
        @(posedge clk); #1;
        rst_n = 1;
        cyc();
        chk("t6_count", 32'(count_o), 0);
        cyc();
        chk("t6_idle", 32'(exc_req_o), 0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            trap_i         = ($urandom_range(0, 99) < 45);
            trap_type_i    = 3'($urandom_range(0, 7));
            trap_pc_i      = $urandom;
            trap_tag_i     = 4'($urandom_range(0, 15));
            csr_pop_i      = ($urandom_range(0, 99) < 30);
            exc_ack_i      = ($urandom_range(0, 99) < 30);
            overflow_clr_i = ($urandom_range(0, 99) < 8);
            cnt_clr_i      = ($urandom_range(0, 99) < 5);
            cnt_sel_i      = 3'($urandom_range(0, 7));
            cyc();
        end

        // Counter saturation and clear-beats-increment
        rst_n = 0; #1; model_reset();
        @(posedge clk); #1;
        rst_n = 1;
        cnt_sel_i = 5;
        for (int i = 0; i < CMAX; i++) begin
            ev(5, 32'h600, 4'h1); cyc();
        end
        chk("t7_full", 32'(cnt_o), 32'hFFFF);
        ev(5, 32'h604, 4'h2); cyc();
        chk("t7_sat", 32'(cnt_o), 32'hFFFF);
        ev(5, 32'h608, 4'h3); cnt_clr_i = 1; cyc();
        chk("t7_clr", 32'(cnt_o), 0);
        ev(5, 32'h60C, 4'h4); cyc();
        chk("t7_inc", 32'(cnt_o), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
